// File: rtl/dma_desc_pkg.sv
// Shared types for the im2col descriptor sequencer: default widths, FSM states, descriptor layout.
// Latency: n/a (types only).
// Backpressure: n/a.
package dma_desc_pkg;

  localparam int ADDR_W_D = 32;
  localparam int INC_W_D  = 23;
  localparam int PAD_W_D  = 8;
  localparam int SIZE_W_D = 16;
  localparam int CNT_W_D  = 16;

  typedef enum logic [2:0] {IDLE, LOAD, ISSUE, WAIT, DRAIN} state_t;

  // rpt doubles as the remaining-repeats counter once a descriptor is in the working register
  typedef struct packed {
    logic [ADDR_W_D-1:0] in_ptr;
    logic [ADDR_W_D-1:0] out_ptr;
    logic [INC_W_D-1:0]  in_inc_d2;
    logic [PAD_W_D-1:0]  pad_top;
    logic [PAD_W_D-1:0]  pad_bottom;
    logic [PAD_W_D-1:0]  pad_left;
    logic [PAD_W_D-1:0]  pad_right;
    logic [SIZE_W_D-1:0] size_d1;
    logic [SIZE_W_D-1:0] size_d2;
    logic [CNT_W_D-1:0]  rpt;
    logic [ADDR_W_D-1:0] in_stride;
    logic [ADDR_W_D-1:0] out_stride;
  } desc_t;

endpackage

// File: rtl/dma_desc_fifo.sv
// Generic FIFO with registered pointers; head is read combinationally from storage.
// Latency: a pushed entry becomes visible at the head the cycle after the push.
// Backpressure: full_o must gate the producer; flush_i empties the queue and drops a coincident push.
module dma_desc_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   flush_i,
  input  logic                   push_i,
  input  logic [W-1:0]           din_i,
  input  logic                   pop_i,
  output logic [W-1:0]           dout_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] level_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  logic [W-1:0] r_mem [DEPTH];
  logic [AW:0]  r_wr;
  logic [AW:0]  r_rd;

  // pointer update; the extra MSB distinguishes full from empty
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wr <= '0;
      r_rd <= '0;
    end else if (flush_i) begin
      r_wr <= '0;
      r_rd <= '0;
    end else begin
      if (push_i) r_wr <= r_wr + 1'b1;
      if (pop_i)  r_rd <= r_rd + 1'b1;
    end
  end

  // storage write, no reset needed since empty_o masks stale entries
  always_ff @(posedge clk_i) begin
    if (push_i && !flush_i) r_mem[r_wr[AW-1:0]] <= din_i;
  end

  assign dout_o  = r_mem[r_rd[AW-1:0]];
  assign level_o = r_wr - r_rd;
  assign full_o  = (level_o == FULL_LVL);
  assign empty_o = (level_o == '0);

endmodule

// File: rtl/dma_desc_seq.sv
// Descriptor sequencer: queues padded 2D transfers, issues each to the DMA, re-issues repeats with strided pointers.
// Latency: push at t -> pop t+1 -> LOAD t+2 -> dma_valid_o at t+3; a repeat re-issues the cycle after dma_done_i.
// Backpressure: push_ready_o low while the FIFO is full; dma_valid_o and fields held stable until dma_ready_i.
module dma_desc_seq
  import dma_desc_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_D,
  parameter int INC_W  = INC_W_D,
  parameter int PAD_W  = PAD_W_D,
  parameter int SIZE_W = SIZE_W_D,
  parameter int CNT_W  = CNT_W_D,
  parameter int DEPTH  = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   enable_i,
  input  logic                   abort_i,
  input  logic                   clear_i,
  input  logic                   push_valid_i,
  output logic                   push_ready_o,
  input  logic [ADDR_W-1:0]      push_in_ptr_i,
  input  logic [ADDR_W-1:0]      push_out_ptr_i,
  input  logic [INC_W-1:0]       push_in_inc_d2_i,
  input  logic [PAD_W-1:0]       push_pad_top_i,
  input  logic [PAD_W-1:0]       push_pad_bottom_i,
  input  logic [PAD_W-1:0]       push_pad_left_i,
  input  logic [PAD_W-1:0]       push_pad_right_i,
  input  logic [SIZE_W-1:0]      push_size_d1_i,
  input  logic [SIZE_W-1:0]      push_size_d2_i,
  input  logic [CNT_W-1:0]       push_rpt_i,
  input  logic [ADDR_W-1:0]      push_in_stride_i,
  input  logic [ADDR_W-1:0]      push_out_stride_i,
  output logic                   dma_valid_o,
  input  logic                   dma_ready_i,
  output logic [ADDR_W-1:0]      dma_in_ptr_o,
  output logic [ADDR_W-1:0]      dma_out_ptr_o,
  output logic [INC_W-1:0]       dma_in_inc_d2_o,
  output logic [PAD_W-1:0]       dma_pad_top_o,
  output logic [PAD_W-1:0]       dma_pad_bottom_o,
  output logic [PAD_W-1:0]       dma_pad_left_o,
  output logic [PAD_W-1:0]       dma_pad_right_o,
  output logic [SIZE_W-1:0]      dma_size_d1_o,
  output logic [SIZE_W-1:0]      dma_size_d2_o,
  input  logic                   dma_done_i,
  output logic                   busy_o,
  output logic                   irq_o,
  output logic                   err_o,
  output logic [CNT_W-1:0]       done_cnt_o,
  output logic [$clog2(DEPTH):0] level_o
);

  state_t           r_state;
  desc_t            r_desc;
  logic [CNT_W-1:0] r_done_cnt;
  logic             r_err;
  logic             r_irq;

  desc_t w_push_desc;
  desc_t w_head;
  logic  w_full;
  logic  w_empty;
  logic  w_push;
  logic  w_pop;
  logic  w_zero;
  logic  w_cnt_inc;
  logic  w_err_set;

  assign w_push_desc = '{in_ptr:     push_in_ptr_i,
                         out_ptr:    push_out_ptr_i,
                         in_inc_d2:  push_in_inc_d2_i,
                         pad_top:    push_pad_top_i,
                         pad_bottom: push_pad_bottom_i,
                         pad_left:   push_pad_left_i,
                         pad_right:  push_pad_right_i,
                         size_d1:    push_size_d1_i,
                         size_d2:    push_size_d2_i,
                         rpt:        push_rpt_i,
                         in_stride:  push_in_stride_i,
                         out_stride: push_out_stride_i};

  // abort drops any push in the same cycle; popping only from IDLE
  assign w_push    = push_valid_i && !w_full && !abort_i;
  assign w_pop     = (r_state == IDLE) && enable_i && !w_empty && !abort_i;
  assign w_zero    = (r_desc.size_d1 == '0) || (r_desc.size_d2 == '0);
  assign w_cnt_inc = (r_state == WAIT) && dma_done_i && !abort_i;
  assign w_err_set = (r_state == LOAD) && w_zero && !abort_i;

  dma_desc_fifo #(
    .W     ($bits(desc_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .flush_i (abort_i),
    .push_i  (w_push),
    .din_i   (w_push_desc),
    .pop_i   (w_pop),
    .dout_o  (w_head),
    .full_o  (w_full),
    .empty_o (w_empty),
    .level_o (level_o)
  );

  // main sequencer: load, issue, wait for completion, stride and re-issue repeats
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= IDLE;
      r_desc  <= '0;
      r_irq   <= 1'b0;
    end else begin
      r_irq <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_pop) begin
            r_desc  <= w_head;
            r_state <= LOAD;
          end
        end
        LOAD: begin
          if (abort_i || w_zero) r_state <= IDLE;
          else                   r_state <= ISSUE;
        end
        ISSUE: begin
          if (abort_i)          r_state <= IDLE;
          else if (dma_ready_i) r_state <= WAIT;
        end
        WAIT: begin
          if (abort_i) begin
            // a completion landing with the abort already ends the transfer
            r_state <= dma_done_i ? IDLE : DRAIN;
          end else if (dma_done_i) begin
            if (r_desc.rpt == '0) begin
              r_state <= IDLE;
              r_irq   <= w_empty && !w_push;
            end else begin
              r_desc.rpt     <= r_desc.rpt - 1'b1;
              r_desc.in_ptr  <= r_desc.in_ptr + r_desc.in_stride;
              r_desc.out_ptr <= r_desc.out_ptr + r_desc.out_stride;
              r_state        <= ISSUE;
            end
          end
        end
        DRAIN: begin
          if (dma_done_i) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // completion counter and sticky error; clear beats a coincident update
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_done_cnt <= '0;
      r_err      <= 1'b0;
    end else if (clear_i) begin
      r_done_cnt <= '0;
      r_err      <= 1'b0;
    end else begin
      if (w_cnt_inc) r_done_cnt <= r_done_cnt + 1'b1;
      if (w_err_set) r_err      <= 1'b1;
    end
  end

  assign push_ready_o     = !w_full;
  assign dma_valid_o      = (r_state == ISSUE);
  assign dma_in_ptr_o     = r_desc.in_ptr;
  assign dma_out_ptr_o    = r_desc.out_ptr;
  assign dma_in_inc_d2_o  = r_desc.in_inc_d2;
  assign dma_pad_top_o    = r_desc.pad_top;
  assign dma_pad_bottom_o = r_desc.pad_bottom;
  assign dma_pad_left_o   = r_desc.pad_left;
  assign dma_pad_right_o  = r_desc.pad_right;
  assign dma_size_d1_o    = r_desc.size_d1;
  assign dma_size_d2_o    = r_desc.size_d2;
  assign busy_o           = (r_state != IDLE) || !w_empty;
  assign irq_o            = r_irq;
  assign err_o            = r_err;
  assign done_cnt_o       = r_done_cnt;

endmodule

// File: tb/tb_dma_desc_seq.sv
// Directed bench for dma_desc_seq: inputs driven on the falling edge, outputs sampled on the falling edge.
// Latency: checks the t+3 first-issue and next-cycle repeat re-issue timing.
// Backpressure: exercises FIFO full, held dma_valid_o, abort drain and asynchronous reset.
module tb_dma_desc_seq;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        enable_i, abort_i, clear_i;
  logic        push_valid_i, push_ready_o;
  logic [31:0] push_in_ptr_i, push_out_ptr_i;
  logic [22:0] push_in_inc_d2_i;
  logic [7:0]  push_pad_top_i, push_pad_bottom_i, push_pad_left_i, push_pad_right_i;
  logic [15:0] push_size_d1_i, push_size_d2_i, push_rpt_i;
  logic [31:0] push_in_stride_i, push_out_stride_i;
  logic        dma_valid_o, dma_ready_i;
  logic [31:0] dma_in_ptr_o, dma_out_ptr_o;
  logic [22:0] dma_in_inc_d2_o;
  logic [7:0]  dma_pad_top_o, dma_pad_bottom_o, dma_pad_left_o, dma_pad_right_o;
  logic [15:0] dma_size_d1_o, dma_size_d2_o;
  logic        dma_done_i;
  logic        busy_o, irq_o, err_o;
  logic [15:0] done_cnt_o;
  logic [2:0]  level_o;

  int          checks = 0;
  int          errors = 0;
  int          n_hs   = 0;
  int          n_irq  = 0;
  logic [31:0] hs_in  [64];
  logic [31:0] hs_out [64];

  dma_desc_seq dut (
    .clk_i             (clk_i),
    .rst_i             (rst_i),
    .enable_i          (enable_i),
    .abort_i           (abort_i),
    .clear_i           (clear_i),
    .push_valid_i      (push_valid_i),
    .push_ready_o      (push_ready_o),
    .push_in_ptr_i     (push_in_ptr_i),
    .push_out_ptr_i    (push_out_ptr_i),
    .push_in_inc_d2_i  (push_in_inc_d2_i),
    .push_pad_top_i    (push_pad_top_i),
    .push_pad_bottom_i (push_pad_bottom_i),
    .push_pad_left_i   (push_pad_left_i),
    .push_pad_right_i  (push_pad_right_i),
    .push_size_d1_i    (push_size_d1_i),
    .push_size_d2_i    (push_size_d2_i),
    .push_rpt_i        (push_rpt_i),
    .push_in_stride_i  (push_in_stride_i),
    .push_out_stride_i (push_out_stride_i),
    .dma_valid_o       (dma_valid_o),
    .dma_ready_i       (dma_ready_i),
    .dma_in_ptr_o      (dma_in_ptr_o),
    .dma_out_ptr_o     (dma_out_ptr_o),
    .dma_in_inc_d2_o   (dma_in_inc_d2_o),
    .dma_pad_top_o     (dma_pad_top_o),
    .dma_pad_bottom_o  (dma_pad_bottom_o),
    .dma_pad_left_o    (dma_pad_left_o),
    .dma_pad_right_o   (dma_pad_right_o),
    .dma_size_d1_o     (dma_size_d1_o),
    .dma_size_d2_o     (dma_size_d2_o),
    .dma_done_i        (dma_done_i),
    .busy_o            (busy_o),
    .irq_o             (irq_o),
    .err_o             (err_o),
    .done_cnt_o        (done_cnt_o),
    .level_o           (level_o)
  );

  always #5 clk_i = ~clk_i;

  // log every DMA handshake and every irq pulse
  always @(posedge clk_i) begin
    if (dma_valid_o && dma_ready_i && n_hs < 64) begin
      hs_in[n_hs]  = dma_in_ptr_o;
      hs_out[n_hs] = dma_out_ptr_o;
      n_hs++;
    end
    if (irq_o) n_irq++;
  end

  task automatic push_desc(input logic [31:0] ip, input logic [31:0] op,
                           input logic [15:0] d1, input logic [15:0] d2, input logic [15:0] rpt,
                           input logic [31:0] is, input logic [31:0] os);
    push_in_ptr_i     = ip;
    push_out_ptr_i    = op;
    push_size_d1_i    = d1;
    push_size_d2_i    = d2;
    push_rpt_i        = rpt;
    push_in_stride_i  = is;
    push_out_stride_i = os;
    push_valid_i      = 1'b1;
    @(negedge clk_i);
    push_valid_i      = 1'b0;
  endtask

  task automatic pulse_clear();
    clear_i = 1'b1;
    @(negedge clk_i);
    clear_i = 1'b0;
  endtask

  task automatic wait_valid(input string name);
    int t;
    t = 0;
    while (!dma_valid_o && t < 100) begin
      @(negedge clk_i);
      t++;
    end
    checks++;
    if (dma_valid_o !== 1'b1) begin
      errors++;
      $display("FAIL %s: dma_valid_o=%b after %0d cycles, required 1", name, dma_valid_o, t);
    end
  endtask

  // DMA responder: accept each offer (ready held high) and pulse done dly cycles later
  task automatic dma_serve(input int n, input int dly);
    for (int k = 0; k < n; k++) begin
      wait_valid("serve_timeout");
      @(negedge clk_i);
      repeat (dly - 1) @(negedge clk_i);
      dma_done_i = 1'b1;
      @(negedge clk_i);
      dma_done_i = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    repeat (3) @(negedge clk_i);
    rst_i = 1'b0;
    @(negedge clk_i);
    checks++; if (push_ready_o !== 1'b1) begin errors++; $display("FAIL reset_push_ready: got %b, required 1", push_ready_o); end
    checks++; if (dma_valid_o !== 1'b0) begin errors++; $display("FAIL reset_dma_valid: got %b, required 0", dma_valid_o); end
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b, required 0", busy_o); end
    checks++; if (irq_o !== 1'b0) begin errors++; $display("FAIL reset_irq: got %b, required 0", irq_o); end
    checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL reset_err: got %b, required 0", err_o); end
    checks++; if (done_cnt_o !== 16'd0) begin errors++; $display("FAIL reset_done_cnt: got %0d, required 0", done_cnt_o); end
    checks++; if (level_o !== 3'd0) begin errors++; $display("FAIL reset_level: got %0d, required 0", level_o); end
    checks++; if (dma_in_ptr_o !== 32'h0) begin errors++; $display("FAIL reset_in_ptr: got %h, required 0", dma_in_ptr_o); end
  endtask

  task automatic test_single();
    int hs0, irq0;
    hs0 = n_hs; irq0 = n_irq;
    push_desc(32'h1000, 32'h2000, 16'd4, 16'd3, 16'd0, 32'h0, 32'h0);
    checks++; if (dma_valid_o !== 1'b0 || level_o !== 3'd1) begin errors++; $display("FAIL single_t1: valid=%b level=%0d, required 0/1", dma_valid_o, level_o); end
    @(negedge clk_i);
    checks++; if (dma_valid_o !== 1'b0 || busy_o !== 1'b1) begin errors++; $display("FAIL single_t2: valid=%b busy=%b, required 0/1", dma_valid_o, busy_o); end
    @(negedge clk_i);
    checks++; if (dma_valid_o !== 1'b1) begin errors++; $display("FAIL single_t3_valid: got %b, required 1", dma_valid_o); end
    checks++; if (dma_in_ptr_o !== 32'h1000 || dma_out_ptr_o !== 32'h2000) begin errors++; $display("FAIL single_ptrs: in=%h out=%h, required 1000/2000", dma_in_ptr_o, dma_out_ptr_o); end
    checks++; if ({dma_pad_top_o, dma_pad_bottom_o, dma_pad_left_o, dma_pad_right_o} !== 32'h01020304) begin errors++; $display("FAIL single_pads: got %h, required 01020304", {dma_pad_top_o, dma_pad_bottom_o, dma_pad_left_o, dma_pad_right_o}); end
    checks++; if (dma_in_inc_d2_o !== 23'h123 || dma_size_d1_o !== 16'd4 || dma_size_d2_o !== 16'd3) begin errors++; $display("FAIL single_fields: inc=%h d1=%0d d2=%0d, required 123/4/3", dma_in_inc_d2_o, dma_size_d1_o, dma_size_d2_o); end
    @(negedge clk_i);
    checks++; if (dma_valid_o !== 1'b0) begin errors++; $display("FAIL single_one_beat: valid=%b, required 0", dma_valid_o); end
    repeat (9) @(negedge clk_i);
    dma_done_i = 1'b1;
    @(negedge clk_i);
    dma_done_i = 1'b0;
    checks++; if (irq_o !== 1'b1) begin errors++; $display("FAIL single_irq: got %b, required 1", irq_o); end
    checks++; if (done_cnt_o !== 16'd1) begin errors++; $display("FAIL single_done_cnt: got %0d, required 1", done_cnt_o); end
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL single_busy: got %b, required 0", busy_o); end
    @(negedge clk_i);
    checks++; if (irq_o !== 1'b0) begin errors++; $display("FAIL single_irq_pulse: got %b, required 0", irq_o); end
    checks++; if (n_hs - hs0 != 1 || n_irq - irq0 != 1) begin errors++; $display("FAIL single_counts: handshakes=%0d irqs=%0d, required 1/1", n_hs - hs0, n_irq - irq0); end
  endtask

  task automatic test_repeat();
    int hs0, irq0;
    pulse_clear();
    hs0 = n_hs; irq0 = n_irq;
    push_desc(32'h1000, 32'h2000, 16'd4, 16'd3, 16'd2, 32'h40, 32'h80);
    wait_valid("repeat_first_valid");
    @(negedge clk_i);
    repeat (4) @(negedge clk_i);
    dma_done_i = 1'b1;
    @(negedge clk_i);
    dma_done_i = 1'b0;
    checks++; if (dma_valid_o !== 1'b1 || dma_in_ptr_o !== 32'h1040 || dma_out_ptr_o !== 32'h2080) begin errors++; $display("FAIL repeat_reissue: valid=%b in=%h out=%h, required 1/1040/2080", dma_valid_o, dma_in_ptr_o, dma_out_ptr_o); end
    checks++; if (done_cnt_o !== 16'd1 || irq_o !== 1'b0) begin errors++; $display("FAIL repeat_mid: cnt=%0d irq=%b, required 1/0", done_cnt_o, irq_o); end
    dma_serve(2, 5);
    repeat (3) @(negedge clk_i);
    checks++; if (n_hs - hs0 != 3) begin errors++; $display("FAIL repeat_issues: got %0d, required 3", n_hs - hs0); end
    checks++; if (hs_in[hs0] !== 32'h1000 || hs_in[hs0+1] !== 32'h1040 || hs_in[hs0+2] !== 32'h1080) begin errors++; $display("FAIL repeat_in_ptrs: %h %h %h, required 1000 1040 1080", hs_in[hs0], hs_in[hs0+1], hs_in[hs0+2]); end
    checks++; if (hs_out[hs0] !== 32'h2000 || hs_out[hs0+1] !== 32'h2080 || hs_out[hs0+2] !== 32'h2100) begin errors++; $display("FAIL repeat_out_ptrs: %h %h %h, required 2000 2080 2100", hs_out[hs0], hs_out[hs0+1], hs_out[hs0+2]); end
    checks++; if (done_cnt_o !== 16'd3) begin errors++; $display("FAIL repeat_done_cnt: got %0d, required 3", done_cnt_o); end
    checks++; if (n_irq - irq0 != 1) begin errors++; $display("FAIL repeat_irq_count: got %0d, required 1", n_irq - irq0); end
  endtask

  task automatic test_fifo_full();
    int hs0, irq0;
    logic exp_rdy;
    hs0 = n_hs; irq0 = n_irq;
    enable_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      exp_rdy = (i < 4);
      checks++; if (push_ready_o !== exp_rdy) begin errors++; $display("FAIL full_push_ready_%0d: got %b, required %b", i, push_ready_o, exp_rdy); end
      push_desc(32'(32'h3000 + i * 256), 32'(32'h4000 + i * 256), 16'd2, 16'd2, 16'd0, 32'h0, 32'h0);
    end
    checks++; if (level_o !== 3'd4 || push_ready_o !== 1'b0) begin errors++; $display("FAIL full_level: level=%0d ready=%b, required 4/0", level_o, push_ready_o); end
    checks++; if (dma_valid_o !== 1'b0) begin errors++; $display("FAIL full_blocked: valid=%b, required 0", dma_valid_o); end
    enable_i = 1'b1;
    dma_serve(4, 3);
    repeat (5) @(negedge clk_i);
    checks++; if (n_hs - hs0 != 4) begin errors++; $display("FAIL full_issues: got %0d, required 4", n_hs - hs0); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (hs_in[hs0+i] !== 32'(32'h3000 + i * 256)) begin errors++; $display("FAIL full_order_%0d: got %h, required %h", i, hs_in[hs0+i], 32'(32'h3000 + i * 256)); end
    end
    checks++; if (level_o !== 3'd0 || n_irq - irq0 != 1) begin errors++; $display("FAIL full_end: level=%0d irqs=%0d, required 0/1", level_o, n_irq - irq0); end
  endtask

  task automatic test_zero_size();
    int hs0;
    pulse_clear();
    hs0 = n_hs;
    push_desc(32'h5000, 32'h5800, 16'd4, 16'd4, 16'd0, 32'h0, 32'h0);
    push_desc(32'h5100, 32'h5900, 16'd4, 16'd0, 16'd0, 32'h0, 32'h0);
    push_desc(32'h5200, 32'h5a00, 16'd4, 16'd4, 16'd0, 32'h0, 32'h0);
    dma_serve(2, 4);
    repeat (5) @(negedge clk_i);
    checks++; if (err_o !== 1'b1) begin errors++; $display("FAIL zero_err: got %b, required 1", err_o); end
    checks++; if (done_cnt_o !== 16'd2) begin errors++; $display("FAIL zero_done_cnt: got %0d, required 2", done_cnt_o); end
    checks++; if (n_hs - hs0 != 2 || hs_in[hs0] !== 32'h5000 || hs_in[hs0+1] !== 32'h5200) begin errors++; $display("FAIL zero_issues: n=%0d %h %h, required 2 5000 5200", n_hs - hs0, hs_in[hs0], hs_in[hs0+1]); end
    pulse_clear();
    checks++; if (err_o !== 1'b0 || done_cnt_o !== 16'd0) begin errors++; $display("FAIL zero_clear: err=%b cnt=%0d, required 0/0", err_o, done_cnt_o); end
  endtask

  task automatic test_abort();
    int hs0, irq0;
    pulse_clear();
    hs0 = n_hs; irq0 = n_irq;
    push_desc(32'h6000, 32'h6800, 16'd2, 16'd2, 16'd0, 32'h0, 32'h0);
    push_desc(32'h6100, 32'h6900, 16'd2, 16'd2, 16'd0, 32'h0, 32'h0);
    push_desc(32'h6200, 32'h6a00, 16'd2, 16'd2, 16'd0, 32'h0, 32'h0);
    wait_valid("abort_first_valid");
    @(negedge clk_i);
    checks++; if (level_o !== 3'd2 || dma_valid_o !== 1'b0) begin errors++; $display("FAIL abort_wait_level: level=%0d valid=%b, required 2/0", level_o, dma_valid_o); end
    abort_i = 1'b1;
    push_in_ptr_i = 32'h6300;
    push_valid_i = 1'b1;
    @(negedge clk_i);
    abort_i = 1'b0;
    push_valid_i = 1'b0;
    checks++; if (level_o !== 3'd0 || busy_o !== 1'b1) begin errors++; $display("FAIL abort_flush: level=%0d busy=%b, required 0/1", level_o, busy_o); end
    repeat (5) @(negedge clk_i);
    checks++; if (dma_valid_o !== 1'b0 || busy_o !== 1'b1) begin errors++; $display("FAIL abort_drain: valid=%b busy=%b, required 0/1", dma_valid_o, busy_o); end
    dma_done_i = 1'b1;
    @(negedge clk_i);
    dma_done_i = 1'b0;
    checks++; if (busy_o !== 1'b0 || done_cnt_o !== 16'd0) begin errors++; $display("FAIL abort_idle: busy=%b cnt=%0d, required 0/0", busy_o, done_cnt_o); end
    repeat (5) @(negedge clk_i);
    checks++; if (n_irq - irq0 != 0 || n_hs - hs0 != 1) begin errors++; $display("FAIL abort_counts: irqs=%0d handshakes=%0d, required 0/1", n_irq - irq0, n_hs - hs0); end
  endtask

  task automatic test_wrap_reset();
    int hs0;
    hs0 = n_hs;
    push_desc(32'hFFFF_FFC0, 32'h7000, 16'd8, 16'd8, 16'd1, 32'h80, 32'h10);
    dma_serve(2, 2);
    repeat (3) @(negedge clk_i);
    checks++; if (n_hs - hs0 != 2 || hs_in[hs0+1] !== 32'h0000_0040 || hs_out[hs0+1] !== 32'h7010) begin errors++; $display("FAIL wrap_ptrs: n=%0d in=%h out=%h, required 2/00000040/7010", n_hs - hs0, hs_in[hs0+1], hs_out[hs0+1]); end
    dma_ready_i = 1'b0;
    push_desc(32'h8000, 32'h8800, 16'd2, 16'd2, 16'd0, 32'h0, 32'h0);
    wait_valid("reset_issue_valid");
    @(negedge clk_i);
    checks++; if (dma_valid_o !== 1'b1 || dma_in_ptr_o !== 32'h8000) begin errors++; $display("FAIL issue_held: valid=%b in=%h, required 1/8000", dma_valid_o, dma_in_ptr_o); end
    #2 rst_i = 1'b1;
    #1;
    checks++; if (dma_valid_o !== 1'b0 || busy_o !== 1'b0 || push_ready_o !== 1'b1) begin errors++; $display("FAIL async_reset: valid=%b busy=%b ready=%b, required 0/0/1", dma_valid_o, busy_o, push_ready_o); end
    checks++; if (done_cnt_o !== 16'd0 || level_o !== 3'd0 || dma_in_ptr_o !== 32'h0) begin errors++; $display("FAIL async_reset_regs: cnt=%0d level=%0d in=%h, required 0/0/0", done_cnt_o, level_o, dma_in_ptr_o); end
    @(negedge clk_i);
    rst_i = 1'b0;
    dma_ready_i = 1'b1;
  endtask

  initial begin
    rst_i = 1'b1;
    enable_i = 1'b1; abort_i = 1'b0; clear_i = 1'b0;
    push_valid_i = 1'b0;
    push_in_ptr_i = '0; push_out_ptr_i = '0;
    push_in_inc_d2_i = 23'h123;
    push_pad_top_i = 8'd1; push_pad_bottom_i = 8'd2; push_pad_left_i = 8'd3; push_pad_right_i = 8'd4;
    push_size_d1_i = '0; push_size_d2_i = '0; push_rpt_i = '0;
    push_in_stride_i = '0; push_out_stride_i = '0;
    dma_ready_i = 1'b1; dma_done_i = 1'b0;
    @(negedge clk_i);
    test_reset();
    test_single();
    test_repeat();
    test_fifo_full();
    test_zero_size();
    test_abort();
    test_wrap_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dma_desc_seq.md
Name: dma_desc_seq

Overview:
- Parametrised descriptor sequencer for the im2col DMA path.
- Queues 2D padded-transfer descriptors (input/output pointers, dim-2 increment, four zero-padding counts, two sizes) in a FIFO.
- Issues them to the DMA with valid/ready and waits for completion after each one.
- Repeat mode re-issues a descriptor N extra times, advancing both pointers by programmable strides, so whole im2col batches run without CPU involvement.

Parameters:
ADDR_W, 32, pointer and stride width
INC_W, 23, dim-2 input increment width
PAD_W, 8, width of each zero-padding count
SIZE_W, 16, width of size_d1/size_d2 in data units
CNT_W, 16, repeat-count and done-counter width
DEPTH, 4, descriptor FIFO entries (power of two, >=2)

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous, active-high reset
enable_i  in  1  allows popping new descriptors
abort_i  in  1  flush queue and stop
clear_i  in  1  clears err_o and done_cnt_o
push_valid_i  in  1  descriptor valid
push_ready_o  out  1  FIFO not full
push_in_ptr_i  in  ADDR_W  input pointer
push_out_ptr_i  in  ADDR_W  output pointer
push_in_inc_d2_i  in  INC_W  dim-2 input increment
push_pad_top_i/bottom_i/left_i/right_i  in  PAD_W each  zero padding
push_size_d1_i, push_size_d2_i  in  SIZE_W each  transfer sizes
push_rpt_i  in  CNT_W  extra repetitions (0 = issue once)
push_in_stride_i, push_out_stride_i  in  ADDR_W each  per-repeat pointer increments
dma_valid_o  out  1  descriptor offered to DMA
dma_ready_i  in  1  DMA accepts
dma_in_ptr_o ... dma_size_d2_o  out  same widths as push fields (no rpt/strides)
dma_done_i  in  1  one-cycle pulse, DMA transfer finished
busy_o  out  1  state != IDLE or FIFO non-empty
irq_o  out  1  one-cycle pulse: batch complete
err_o  out  1  sticky: zero-size descriptor discarded
done_cnt_o  out  CNT_W  completed transfers, wraps
level_o  out  $clog2(DEPTH)+1  FIFO occupancy

Behaviour:
- Reset: all outputs 0 except push_ready_o=1. FIFO empty, state IDLE, working registers 0.
- FIFO:
  - Push when push_valid_i && push_ready_o; push_ready_o = !full.
  - No bypass: a pushed entry is poppable the next cycle. Push and pop in the same cycle are allowed when not full.
- States:
  - IDLE: if enable_i && !empty && !abort_i, pop the head into working registers, remaining<=push_rpt, go to LOAD.
  - LOAD: if size_d1==0 or size_d2==0, set err_o and go to IDLE (descriptor discarded, not counted). Otherwise go to ISSUE.
  - ISSUE: dma_valid_o=1; dma_*_o driven directly from working registers and held stable. On dma_ready_i go to WAIT.
  - WAIT: on dma_done_i, done_cnt++.
    - If remaining==0: go to IDLE; irq_o pulses the same cycle the FIFO is empty and no push is occurring.
    - Else: remaining--, in_ptr+=in_stride, out_ptr+=out_stride (modulo 2^ADDR_W), go to ISSUE.
  - DRAIN: entered on abort; on dma_done_i go to IDLE without counting.
- Latency: push at cycle t (empty FIFO, enable high, DMA ready) -> pop at t+1, LOAD at t+2, dma_valid_o high at t+3. A repeat re-issue asserts dma_valid_o in the cycle after the done pulse.
- dma_done_i is ignored outside WAIT/DRAIN.
- dma_done_i in the same cycle as dma_ready_i is not legal DMA behaviour; done is ignored in ISSUE.
- abort_i (priority over all):
  - FIFO flushed.
  - ISSUE/LOAD/IDLE -> IDLE next cycle; dma_valid_o deasserts next cycle.
  - WAIT -> DRAIN.
  - A push in the abort cycle is dropped.
  - No irq_o.
- clear_i zeroes err_o and done_cnt_o. If coincident with an increment, clear wins.
- enable_i low only blocks popping; an in-progress descriptor and its repeats complete.
- Reset mid-operation returns everything to reset values immediately (asynchronous).

Decomposition:
- Package dma_desc_pkg:
  - default width localparams;
  - state enum {IDLE, LOAD, ISSUE, WAIT, DRAIN};
  - packed descriptor struct typedef at the default widths, used for FIFO storage and the working register.
- Sub-module dma_desc_fifo: parametrised width/DEPTH, synchronous-pop FIFO with full/empty/level.

Test Plan:
- Single descriptor (in 0x1000, out 0x2000, d1=4, d2=3, rpt=0), DMA ready, done 10 cycles after issue -> dma_valid_o at t+3, one handshake, done_cnt_o=1, irq_o pulse, busy_o low.
- rpt=2, strides 0x40/0x80 -> three issues with in_ptr 0x1000/0x1040/0x1080 and out_ptr 0x2000/0x2080/0x2100; done_cnt_o=3, exactly one irq_o.
- Push 5 descriptors with enable_i=0, DEPTH=4 -> push_ready_o low after 4 pushes, level_o=4; raise enable -> FIFO order preserved, 4 completions.
- Descriptor with size_d2=0 between two valid ones -> err_o set, only 2 issues, done_cnt_o=2; clear_i -> err_o=0, done_cnt_o=0.
- abort_i during WAIT with 2 entries queued -> level_o=0 next cycle, DRAIN until dma_done_i, no count increment, no irq_o, then IDLE.
- Stride wrap: in_ptr 0xFFFF_FFC0, stride 0x80, rpt=1 -> second in_ptr 0x0000_0040; reset asserted in ISSUE -> dma_valid_o=0 immediately.
